// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with load-use and early-operand hazard detection.
// Optional STALL_WATCHDOG_EN adds a saturating stall-timeout counter.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned WD_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inst_stall_i,
  input  logic                 data_stall_i,
  input  logic                 ex_busy_i,
  input  logic                 exc_valid_i,
  input  logic                 exc_is_eret_i,
  input  logic [31:0]          cp0_epc_i,
  input  logic [NUM_SRC*5-1:0] id_src_addr_i,
  input  logic [NUM_SRC-1:0]   id_src_ren_i,
  input  logic                 id_needs_early_i,
  input  logic                 ex_wreg_i,
  input  logic [4:0]           ex_wd_i,
  input  logic [NUM_SRC*5-1:0] ex_src_addr_i,
  input  logic [NUM_SRC-1:0]   ex_src_ren_i,
  input  logic                 mem_is_load_i,
  input  logic [4:0]           mem_wd_i,
  output logic [STAGES-1:0]    stage_stall_o,
  output logic [STAGES-1:0]    stage_flush_o,
  output logic                 stall_all_o,
  output logic                 flush_o,
  output logic [31:0]          new_pc_o,
  output logic                 watchdog_o
);

  typedef enum logic [1:0] {
    RUN,
    PEND,
    FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        ex_hazard, id_hazard;
  logic [WD_W-1:0] wd_cnt_q;

  assign stall_all_o = inst_stall_i | data_stall_i | ex_busy_i;

  // Operand compares; register 0 is hardwired and never a hazard
  always_comb begin
    ex_hazard = 1'b0;
    id_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_src_ren_i[i] && (mem_wd_i != 5'd0) &&
          (ex_src_addr_i[i*5 +: 5] == mem_wd_i))
        ex_hazard = 1'b1;
      if (id_src_ren_i[i] && (ex_wd_i != 5'd0) &&
          (id_src_addr_i[i*5 +: 5] == ex_wd_i))
        id_hazard = 1'b1;
    end
    ex_hazard = ex_hazard & mem_is_load_i;
    id_hazard = id_hazard & id_needs_early_i & ex_wreg_i;
  end

  // Per-stage hold/bubble vectors by priority
  always_comb begin
    stage_stall_o = '0;
    stage_flush_o = '0;
    if (flush_o) begin
      stage_flush_o = '1;
    end else if (stall_all_o) begin
      stage_stall_o = '1;
    end else if (ex_hazard) begin
      stage_stall_o[2:0] = 3'b111;
      stage_flush_o[3]   = 1'b1;
    end else if (id_hazard) begin
      stage_stall_o[1:0] = 2'b11;
      stage_flush_o[2]   = 1'b1;
    end
    if (rst_i)
      stage_flush_o = '1;
  end

  // Redirect FSM state and latched target
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Redirect FSM next state; first exception wins until the pulse
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      RUN: begin
        if (exc_valid_i) begin
          target_d = exc_is_eret_i ? cp0_epc_i : EXC_VECTOR;
          state_d  = stall_all_o ? PEND : FLUSH;
        end
      end
      PEND: begin
        if (!stall_all_o)
          state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign flush_o  = (state_q == FLUSH);
  assign new_pc_o = target_q;

`ifdef STALL_WATCHDOG_EN
  // Count consecutive stalled cycles, saturating at all ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      wd_cnt_q <= '0;
    else if (!stall_all_o)
      wd_cnt_q <= '0;
    else if (!(&wd_cnt_q))
      wd_cnt_q <= wd_cnt_q + 1'b1;
  end
`else
  assign wd_cnt_q = '0;
`endif

  assign watchdog_o = &wd_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the pipeline stall/flush controller.
- Generates per-stage stall and flush vectors for a STAGES-deep in-order pipeline: stage 0 = PC/IF, stage k = register between stage k-1 and k.
- Detects ID-stage and EX-stage operand hazards; ignores $0.
- Exception/ERET redirects go through a registered flush state machine. An exception raised during a global stall (cache miss, busy divider) is held pending until the stall clears.

Parameters:
- STAGES, 5, number of stall/flush controlled pipeline points (min 4).
- NUM_SRC, 2, source operands checked per instruction.
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- WD_W, 8, stall watchdog counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- inst_stall_i  in  1  I-side memory not ready
- data_stall_i  in  1  D-side memory not ready
- ex_busy_i  in  1  multicycle EX unit not done
- exc_valid_i  in  1  exception or ERET committed in MEM this cycle
- exc_is_eret_i  in  1  qualifies exc_valid_i as ERET
- cp0_epc_i  in  32  EPC for ERET
- id_src_addr_i  in  NUM_SRC*5  ID source register numbers
- id_src_ren_i  in  NUM_SRC  ID source read enables
- id_needs_early_i  in  1  ID instruction is a branch or address calculation needing operands in ID
- ex_wreg_i  in  1  EX writes a register
- ex_wd_i  in  5  EX destination register
- ex_src_addr_i  in  NUM_SRC*5  EX source register numbers
- ex_src_ren_i  in  NUM_SRC  EX source read enables
- mem_is_load_i  in  1  MEM holds a load
- mem_wd_i  in  5  MEM destination register
- stage_stall_o  out  STAGES  hold for each pipeline point
- stage_flush_o  out  STAGES  clear (bubble) for each pipeline point
- stall_all_o  out  1  global stall
- flush_o  out  1  redirect pulse
- new_pc_o  out  32  redirect target, valid while flush_o
- watchdog_o  out  1  stall timeout flag

Behaviour:
- Reset (async): FSM=RUN, flush_o=0, new_pc_o=0, pending latch cleared, watchdog counter=0, watchdog_o=0. Combinational outputs follow their inputs during reset; stage_flush_o is forced all-ones while rst_i=1.
- stall_all_o = inst_stall_i | data_stall_i | ex_busy_i (combinational).
- Address 0 never matches in any hazard compare.
- ex_hazard = mem_is_load_i & (any i: ex_src_ren_i[i] & ex_src_addr_i[i]==mem_wd_i).
- id_hazard = id_needs_early_i & ex_wreg_i & (any i: id_src_ren_i[i] & id_src_addr_i[i]==ex_wd_i).
- Priority per cycle: flush_o > stall_all_o > ex_hazard > id_hazard.
  - flush_o: stage_flush_o all ones, stage_stall_o all zeros.
  - stall_all_o: stage_stall_o all ones, no flush.
  - ex_hazard: stall stages 0..2, flush stage 3.
  - id_hazard: stall stages 0..1, flush stage 2.
  - Stages above the flushed one are neither stalled nor flushed.
- FSM RUN:
  - exc_valid_i & !stall_all_o: latch target, go to FLUSH.
  - exc_valid_i & stall_all_o: latch target, go to PEND.
- FSM PEND: ignore further exc_valid_i (first wins). When stall_all_o falls, go to FLUSH.
- FSM FLUSH: flush_o=1 and new_pc_o=latched target for exactly one cycle, then RUN. exc_valid_i in that cycle is ignored.
- Latency: exception sampled at edge t gives flush_o high in cycle t+1 (registered).
- Target: exc_is_eret_i ? cp0_epc_i (sampled at latch) : EXC_VECTOR.
- Reset mid-PEND or mid-FLUSH aborts the redirect; no flush pulse after reset.

Optional Feature:
- STALL_WATCHDOG_EN defined:
  - WD_W-bit counter increments each cycle stall_all_o=1 and clears when it is 0.
  - Counter saturates at all ones.
  - watchdog_o=1 while the counter is saturated.
- Undefined: no counter, watchdog_o tied 0.

Test Plan:
- id_needs_early=1, id_src_addr[0]=5 ren, ex_wreg=1, ex_wd=5 -> stage_stall=5'b00011, stage_flush=5'b00100; same with ex_wd=0 and src=0 -> no stall.
- mem_is_load=1, mem_wd=7, ex_src_addr[1]=7 ren, plus the id_hazard above -> stage_stall=5'b00111, stage_flush=5'b01000.
- exc_valid=1, eret=0, no stall at edge t -> flush_o=1 in cycle t+1 only, new_pc=32'hBFC00380, stage_flush=5'b11111.
- data_stall held 4 cycles; ERET with epc=32'h80001234 in cycle 1, a second exception in cycle 2 -> no flush while stalled; single flush_o the cycle after data_stall falls, new_pc=32'h80001234.
- Enter PEND, assert rst_i asynchronously mid-cycle -> flush_o=0 immediately, no later pulse, FSM=RUN.
- STALL_WATCHDOG_EN, WD_W=4: inst_stall high 20 cycles -> watchdog_o rises after the 15th stalled cycle and stays high until stall drops, then clears next cycle.
